// File: rtl/bus_trace_buffer_pkg.sv
// Shared definitions for the bus tracer.
//  - FSM state encodings (also the value driven on the 'state' output).
//  - Bit offsets of the fields inside one stored trace entry {SYNC, RW, AB, DB}.
package bus_trace_buffer_pkg;

  typedef logic [1:0] tr_state_t;

  localparam tr_state_t TR_IDLE  = 2'b00;
  localparam tr_state_t TR_ARMED = 2'b01;
  localparam tr_state_t TR_POST  = 2'b10;
  localparam tr_state_t TR_DONE  = 2'b11;

  // Entry layout, LSB first: DB, then AB, then RW, then SYNC.
  localparam int unsigned ENT_DB = 0;

  function automatic int unsigned ent_ab(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned ent_rw(input int unsigned aw, input int unsigned dw);
    return dw + aw;
  endfunction

  function automatic int unsigned ent_sync(input int unsigned aw, input int unsigned dw);
    return dw + aw + 1;
  endfunction

endpackage

// File: rtl/bus_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one write port, one synchronous read port.
// Kept behind its own boundary so a vendor macro can replace it.
// Ports:
//  clock  capture/readout clock
//  we     write enable; waddr/wdata addressed entry
//  re     read enable; rdata updates on the following edge from mem[raddr]
module bus_trace_buffer_trace_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 26,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_trace_buffer.sv
// On-chip bus tracer for the 6502C core, clocked from phi2.
// Captures {SYNC,RW,AB,DB} per cap_en strobe into a ring, freezes a programmable number
// of entries after an address/SYNC trigger, then plays entries back oldest-first.
// Ports:
//  clock, RES_L                 clock and synchronous active-low reset
//  cap_en, AB, DB, RW, SYNC     snooped bus and its sample strobe
//  arm, abort                   start capture (IDLE only) / return to IDLE from anywhere
//  trig_addr/mask/sync          trigger compare; post_count entries kept after trigger
//  rd_req -> rd_data/valid/last pop handshake, one cycle latency, DONE only
//  state, fill, trig_pos        status
module bus_trace_buffer
  import bus_trace_buffer_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             RES_L,
  input  logic             cap_en,
  input  logic [AW-1:0]    AB,
  input  logic [DW-1:0]    DB,
  input  logic             RW,
  input  logic             SYNC,
  input  logic             arm,
  input  logic             abort,
  input  logic [AW-1:0]    trig_addr,
  input  logic [AW-1:0]    trig_mask,
  input  logic             trig_sync,
  input  logic [PW-1:0]    post_count,
  input  logic             rd_req,
  output logic [AW+DW+1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic [1:0]       state,
  output logic [PW:0]      fill,
  output logic [PW-1:0]    trig_pos
);

  localparam int unsigned EW      = AW + DW + 2;
  localparam int unsigned EntAb   = ent_ab(DW);
  localparam int unsigned EntRw   = ent_rw(AW, DW);
  localparam int unsigned EntSync = ent_sync(AW, DW);
  localparam logic [PW:0] FillMax = (PW+1)'(DEPTH);

  tr_state_t     state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   fill_q, fill_d, rd_left_q, rd_left_d;
  logic [PW-1:0] remain_q, remain_d, post_q, post_d, trig_pos_q, trig_pos_d;
  logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;

  logic          hit, we, re, enter_done;
  logic [PW:0]   fill_inc;
  logic [PW-1:0] post_eff;
  logic [EW-1:0] wdata, rdata;

  assign hit = cap_en && (((AB ^ trig_addr) & trig_mask) == '0) && (!trig_sync || SYNC);

  // A PW-bit count can never exceed DEPTH-1, so the clamp to DEPTH-1 is implicit.
  assign post_eff = post_count;
  assign fill_inc = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;

  always_comb begin
    wdata                   = '0;
    wdata[ENT_DB +: DW]     = DB;
    wdata[EntAb +: AW]      = AB;
    wdata[EntRw]            = RW;
    wdata[EntSync]          = SYNC;
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fill_d     = fill_q;
    rd_left_d  = rd_left_q;
    remain_d   = remain_q;
    post_d     = post_q;
    trig_pos_d = trig_pos_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    enter_done = 1'b0;

    if (abort) begin
      state_d = TR_IDLE;
    end else begin
      case (state_q)
        TR_IDLE: begin
          if (arm) begin
            state_d = TR_ARMED;
            fill_d  = '0;
            wptr_d  = '0;
          end
        end
        TR_ARMED: begin
          if (cap_en) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            fill_d = fill_inc;
            if (hit) begin
              post_d   = post_eff;
              remain_d = post_eff;
              if (post_eff == '0) begin
                enter_done = 1'b1;
              end else begin
                state_d = TR_POST;
              end
            end
          end
        end
        TR_POST: begin
          if (cap_en) begin
            we       = 1'b1;
            wptr_d   = wptr_q + 1'b1;
            fill_d   = fill_inc;
            remain_d = remain_q - 1'b1;
            if (remain_q == PW'(1)) enter_done = 1'b1;
          end
        end
        default: begin  // TR_DONE
          if (rd_req) begin
            re         = 1'b1;
            rptr_d     = rptr_q + 1'b1;
            rd_left_d  = rd_left_q - 1'b1;
            rd_valid_d = 1'b1;
            if (rd_left_q == (PW+1)'(1)) begin
              rd_last_d = 1'b1;
              state_d   = TR_IDLE;
            end
          end
        end
      endcase

      // Readout starts at the oldest survivor; with a full ring the low bits of fill
      // are zero and rptr lands on wptr, which is exactly the oldest entry.
      if (enter_done) begin
        state_d    = TR_DONE;
        rptr_d     = wptr_d - fill_d[PW-1:0];
        rd_left_d  = fill_d;
        trig_pos_d = fill_d[PW-1:0] - PW'(1) - post_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!RES_L) begin
      state_q    <= TR_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      rd_left_q  <= '0;
      remain_q   <= '0;
      post_q     <= '0;
      trig_pos_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      rd_left_q  <= rd_left_d;
      remain_q   <= remain_d;
      post_q     <= post_d;
      trig_pos_q <= trig_pos_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  bus_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (PW)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (re),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  // RAM output has no reset, so present zero whenever no pop is being delivered.
  assign rd_data  = rd_valid_q ? rdata : '0;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign state    = state_q;
  assign fill     = fill_q;
  assign trig_pos = trig_pos_q;

endmodule
